// File: rtl/reg_file_issue.sv
// reg_file_issue: sixteen-entry architectural register file with a single
// writeback port, a busy-bit scoreboard and a registered operand-issue stage.
// Optional feature macro: REG_ZERO_HARDWIRED_EN (register 0 hardwired to zero,
// writebacks to it dropped, never marked busy, never bypassed).
module reg_file_issue #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_en,
  input  logic [3:0]            wb_addr,
  input  logic [WIDTH-1:0]      wb_data,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [3:0]            iss_rs1,
  input  logic [3:0]            iss_rs2,
  input  logic [3:0]            iss_rd,
  input  logic                  iss_rd_en,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [WIDTH-1:0]      op_a,
  output logic [WIDTH-1:0]      op_b,
  output logic [3:0]            op_rd,
  output logic                  op_rd_en,
  output logic [16*WIDTH-1:0]   regs_flat,
  output logic [15:0]           busy
);

  logic [WIDTH-1:0] regs_q [16];
  logic [WIDTH-1:0] regs_d [16];
  logic [15:0]      busy_q, busy_d;
  logic             op_valid_q, op_valid_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [3:0]       op_rd_q, op_rd_d;
  logic             op_rd_en_q, op_rd_en_d;

  logic             wb_eff;
  logic             rd_track;
  logic [15:0]      wb_onehot;
  logic [15:0]      eff_busy;
  logic             hazard;
  logic             stage_free;
  logic             accept;
  logic [WIDTH-1:0] src_a, src_b;

`ifdef REG_ZERO_HARDWIRED_EN
  assign wb_eff   = wb_en && (wb_addr != 4'd0);
  assign rd_track = iss_rd_en && (iss_rd != 4'd0);
`else
  assign wb_eff   = wb_en;
  assign rd_track = iss_rd_en;
`endif

  // A writeback landing this cycle already resolves its register's hazard.
  assign wb_onehot  = wb_eff ? (16'h0001 << wb_addr) : 16'h0000;
  assign eff_busy   = busy_q & ~wb_onehot;
  assign hazard     = eff_busy[iss_rs1] || eff_busy[iss_rs2] ||
                      (iss_rd_en && eff_busy[iss_rd]);
  assign stage_free = !op_valid_q || op_ready;
  assign iss_ready  = stage_free && !hazard;
  assign accept     = iss_valid && iss_ready;

  // Source operand selection with same-cycle writeback bypass.
  always_comb begin
    src_a = regs_q[iss_rs1];
    src_b = regs_q[iss_rs2];
    if (wb_eff && (wb_addr == iss_rs1)) src_a = wb_data;
    if (wb_eff && (wb_addr == iss_rs2)) src_b = wb_data;
`ifdef REG_ZERO_HARDWIRED_EN
    if (iss_rs1 == 4'd0) src_a = '0;
    if (iss_rs2 == 4'd0) src_b = '0;
`endif
  end

  // Flat view of the register array for the downstream read muxes.
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < 16; i++) begin
      regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
    end
  end

  // Next-state for the array, the scoreboard and the operand stage; an issue
  // setting busy overrides a writeback clearing the same bit.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      regs_d[i] = regs_q[i];
    end
    busy_d     = busy_q & ~wb_onehot;
    op_valid_d = op_valid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_rd_d    = op_rd_q;
    op_rd_en_d = op_rd_en_q;

    if (wb_eff) regs_d[wb_addr] = wb_data;

    if (accept) begin
      op_valid_d = 1'b1;
      op_a_d     = src_a;
      op_b_d     = src_b;
      op_rd_d    = iss_rd;
      op_rd_en_d = iss_rd_en;
      if (rd_track) busy_d[iss_rd] = 1'b1;
    end else if (op_ready) begin
      op_valid_d = 1'b0;
    end
  end

  // State registers, cleared immediately on reset assertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_rd_q    <= '0;
      op_rd_en_q <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q     <= busy_d;
      op_valid_q <= op_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_rd_q    <= op_rd_d;
      op_rd_en_q <= op_rd_en_d;
    end
  end

  assign busy     = busy_q;
  assign op_valid = op_valid_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_rd    = op_rd_q;
  assign op_rd_en = op_rd_en_q;

endmodule

// File: tb/tb_reg_file_issue.sv
// Testbench for reg_file_issue: directed scenarios plus a randomized run
// against an array-based reference model of the register file and issue stage.
module tb_reg_file_issue;

  localparam int WIDTH = 16;
`ifdef REG_ZERO_HARDWIRED_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               wb_en = 1'b0;
  logic [3:0]         wb_addr = '0;
  logic [WIDTH-1:0]   wb_data = '0;
  logic               iss_valid = 1'b0;
  logic               iss_ready;
  logic [3:0]         iss_rs1 = '0;
  logic [3:0]         iss_rs2 = '0;
  logic [3:0]         iss_rd = '0;
  logic               iss_rd_en = 1'b0;
  logic               op_valid;
  logic               op_ready = 1'b0;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [3:0]         op_rd;
  logic               op_rd_en;
  logic [16*WIDTH-1:0] regs_flat;
  logic [15:0]        busy;

  int tests  = 0;
  int failed = 0;

  // Reference model state
  logic [15:0] m_regs [16];
  bit          m_busy [16];
  bit          m_op_valid;
  logic [15:0] m_op_a, m_op_b;
  logic [3:0]  m_op_rd;
  bit          m_op_rd_en;
  bit          exp_ready;

  reg_file_issue #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_rd_en(iss_rd_en),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_rd_en(op_rd_en),
    .regs_flat(regs_flat), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  task automatic set_in(input logic wbe, input logic [3:0] wa, input logic [15:0] wd,
                        input logic iv, input logic [3:0] r1, input logic [3:0] r2,
                        input logic [3:0] rd, input logic rde, input logic ordy);
    wb_en = wbe; wb_addr = wa; wb_data = wd;
    iss_valid = iv; iss_rs1 = r1; iss_rs2 = r2; iss_rd = rd; iss_rd_en = rde;
    op_ready = ordy;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_op_valid = 1'b0; m_op_a = '0; m_op_b = '0; m_op_rd = '0; m_op_rd_en = 1'b0;
  endtask

  function automatic bit wb_live();
    return wb_en && !(ZERO && wb_addr == 4'd0);
  endfunction

  function automatic bit m_pending(input logic [3:0] r);
    return m_busy[r] && !(wb_live() && wb_addr == r);
  endfunction

  function automatic logic [15:0] m_value(input logic [3:0] r);
    if (ZERO && r == 4'd0) return 16'h0000;
    if (wb_live() && wb_addr == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic logic [15:0] m_busy_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic logic [16*WIDTH-1:0] m_flat();
    logic [16*WIDTH-1:0] v;
    for (int i = 0; i < 16; i++) v[i*WIDTH +: WIDTH] = m_regs[i];
    return v;
  endfunction

  // Evaluate ready for the inputs currently applied.
  task automatic step_begin();
    bit hz;
    #1;
    hz = m_pending(iss_rs1) || m_pending(iss_rs2) || (iss_rd_en && m_pending(iss_rd));
    exp_ready = (!m_op_valid || op_ready) && !hz;
  endtask

  // Apply the model's clock-edge update, then advance past the edge.
  task automatic step_end();
    logic [15:0] va, vb;
    bit acc;
    acc = iss_valid && exp_ready;
    va = m_value(iss_rs1);
    vb = m_value(iss_rs2);
    if (wb_live()) begin
      m_regs[wb_addr] = wb_data;
      m_busy[wb_addr] = 1'b0;
    end
    if (acc) begin
      m_op_valid = 1'b1; m_op_a = va; m_op_b = vb;
      m_op_rd = iss_rd; m_op_rd_en = iss_rd_en;
      if (iss_rd_en && !(ZERO && iss_rd == 4'd0)) m_busy[iss_rd] = 1'b1;
    end else if (op_ready) begin
      m_op_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    tests++; if (op_valid !== 1'b0) begin failed++; $display("[TB] FAIL reset_op_valid got %0b want 0", op_valid); end
    tests++; if (busy !== 16'h0000) begin failed++; $display("[TB] FAIL reset_busy got %h want 0000", busy); end
    tests++; if ({op_a, op_b, op_rd, op_rd_en} !== '0) begin failed++; $display("[TB] FAIL reset_op got a=%h b=%h rd=%h en=%b want 0", op_a, op_b, op_rd, op_rd_en); end
    tests++; if (regs_flat !== '0) begin failed++; $display("[TB] FAIL reset_regs got %h want 0", regs_flat); end
    tests++; if (iss_ready !== 1'b1) begin failed++; $display("[TB] FAIL reset_ready got %0b want 1", iss_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk); set_in(1, 4'd3, 16'hA5A5, 0, 0, 0, 0, 0, 1);
    step_begin(); step_end();
    tests++; if (regs_flat[63:48] !== 16'hA5A5) begin failed++; $display("[TB] FAIL wr_regs3 got %h want a5a5", regs_flat[63:48]); end
    @(negedge clk); set_in(0, 0, 0, 1, 4'd3, 4'd4, 4'd0, 0, 1);
    step_begin();
    tests++; if (iss_ready !== 1'b1) begin failed++; $display("[TB] FAIL wr_ready got %0b want 1", iss_ready); end
    step_end();
    tests++; if (op_valid !== 1'b1) begin failed++; $display("[TB] FAIL wr_op_valid got %0b want 1", op_valid); end
    tests++; if (op_a !== 16'hA5A5) begin failed++; $display("[TB] FAIL wr_op_a got %h want a5a5", op_a); end
    tests++; if (op_b !== 16'h0000) begin failed++; $display("[TB] FAIL wr_op_b got %h want 0000", op_b); end
  endtask

  task automatic test_raw_stall();
    @(negedge clk); set_in(0, 0, 0, 1, 4'd1, 4'd2, 4'd5, 1, 1);
    step_begin();
    tests++; if (iss_ready !== 1'b1) begin failed++; $display("[TB] FAIL raw_first_ready got %0b want 1", iss_ready); end
    step_end();
    tests++; if (busy[5] !== 1'b1) begin failed++; $display("[TB] FAIL raw_busy5 got %0b want 1", busy[5]); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); set_in(0, 0, 0, 1, 4'd5, 4'd1, 4'd2, 0, 1);
      step_begin();
      tests++; if (iss_ready !== 1'b0) begin failed++; $display("[TB] FAIL raw_stall_ready cyc %0d got %0b want 0", c, iss_ready); end
      step_end();
    end
    @(negedge clk); set_in(1, 4'd5, 16'h1234, 1, 4'd5, 4'd1, 4'd2, 0, 1);
    step_begin();
    tests++; if (iss_ready !== 1'b1) begin failed++; $display("[TB] FAIL raw_wb_ready got %0b want 1", iss_ready); end
    step_end();
    tests++; if (op_a !== 16'h1234) begin failed++; $display("[TB] FAIL raw_bypass_op_a got %h want 1234", op_a); end
    tests++; if (busy[5] !== 1'b0) begin failed++; $display("[TB] FAIL raw_busy5_clear got %0b want 0", busy[5]); end
  endtask

  task automatic test_backpressure();
    @(negedge clk); set_in(0, 0, 0, 1, 4'd3, 4'd5, 4'd0, 0, 1);
    step_begin(); step_end();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); set_in(0, 0, 0, 1, 4'd4, 4'd4, 4'd0, 0, 0);
      step_begin();
      tests++; if (iss_ready !== 1'b0) begin failed++; $display("[TB] FAIL bp_ready cyc %0d got %0b want 0", c, iss_ready); end
      step_end();
      tests++; if ({op_valid, op_a, op_b} !== {1'b1, 16'hA5A5, 16'h1234}) begin failed++; $display("[TB] FAIL bp_hold cyc %0d got v=%0b a=%h b=%h want v=1 a=a5a5 b=1234", c, op_valid, op_a, op_b); end
    end
    @(negedge clk); set_in(0, 0, 0, 1, 4'd4, 4'd4, 4'd0, 0, 1);
    step_begin();
    tests++; if (iss_ready !== 1'b1) begin failed++; $display("[TB] FAIL bp_release_ready got %0b want 1", iss_ready); end
    step_end();
    tests++; if ({op_valid, op_a, op_b} !== {1'b1, 16'h0000, 16'h0000}) begin failed++; $display("[TB] FAIL bp_new got v=%0b a=%h b=%h want v=1 a=0 b=0", op_valid, op_a, op_b); end
  endtask

  task automatic test_collision();
    @(negedge clk); set_in(0, 0, 0, 1, 4'd1, 4'd1, 4'd7, 1, 1);
    step_begin(); step_end();
    @(negedge clk); set_in(1, 4'd7, 16'hBEEF, 1, 4'd1, 4'd1, 4'd7, 1, 1);
    step_begin();
    tests++; if (iss_ready !== 1'b1) begin failed++; $display("[TB] FAIL col_ready got %0b want 1", iss_ready); end
    step_end();
    tests++; if (busy[7] !== 1'b1) begin failed++; $display("[TB] FAIL col_busy7 got %0b want 1", busy[7]); end
    tests++; if (regs_flat[127:112] !== 16'hBEEF) begin failed++; $display("[TB] FAIL col_reg7 got %h want beef", regs_flat[127:112]); end
    tests++; if ({op_rd, op_rd_en} !== {4'd7, 1'b1}) begin failed++; $display("[TB] FAIL col_op_rd got rd=%0d en=%0b want rd=7 en=1", op_rd, op_rd_en); end
    @(negedge clk); set_in(1, 4'd7, 16'hBEEF, 0, 0, 0, 0, 0, 1);
    step_begin(); step_end();
  endtask

  task automatic test_zero();
    logic [15:0] exp_z;
    exp_z = ZERO ? 16'h0000 : 16'hFFFF;
    @(negedge clk); set_in(1, 4'd0, 16'hFFFF, 0, 0, 0, 0, 0, 1);
    step_begin(); step_end();
    tests++; if (regs_flat[15:0] !== exp_z) begin failed++; $display("[TB] FAIL zero_reg0 got %h want %h", regs_flat[15:0], exp_z); end
    @(negedge clk); set_in(0, 0, 0, 1, 4'd0, 4'd0, 4'd0, 1, 1);
    step_begin();
    tests++; if (iss_ready !== 1'b1) begin failed++; $display("[TB] FAIL zero_ready got %0b want 1", iss_ready); end
    step_end();
    tests++; if (op_a !== exp_z) begin failed++; $display("[TB] FAIL zero_op_a got %h want %h", op_a, exp_z); end
    tests++; if (busy[0] !== !ZERO) begin failed++; $display("[TB] FAIL zero_busy0 got %0b want %0b", busy[0], !ZERO); end
    @(negedge clk); set_in(1, 4'd0, 16'h0000, 0, 0, 0, 0, 0, 1);
    step_begin(); step_end();
  endtask

  task automatic test_random();
    logic [3:0] busyq [$];
    logic [3:0] wa;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      busyq.delete();
      for (int i = 0; i < 16; i++) if (m_busy[i]) busyq.push_back(4'(i));
      if (busyq.size() > 0 && $urandom_range(0, 3) != 0)
        wa = busyq[$urandom_range(0, busyq.size() - 1)];
      else
        wa = 4'($urandom_range(0, 15));
      set_in(1'($urandom_range(0, 1)), wa, 16'($urandom),
             1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7));
      step_begin();
      tests++; if (iss_ready !== exp_ready) begin failed++; $display("[TB] FAIL rnd_ready cyc %0d got %0b want %0b", c, iss_ready, exp_ready); end
      step_end();
      tests++; if (op_valid !== m_op_valid) begin failed++; $display("[TB] FAIL rnd_op_valid cyc %0d got %0b want %0b", c, op_valid, m_op_valid); end
      tests++; if ({op_a, op_b} !== {m_op_a, m_op_b}) begin failed++; $display("[TB] FAIL rnd_ops cyc %0d got a=%h b=%h want a=%h b=%h", c, op_a, op_b, m_op_a, m_op_b); end
      tests++; if ({op_rd, op_rd_en} !== {m_op_rd, m_op_rd_en}) begin failed++; $display("[TB] FAIL rnd_op_rd cyc %0d got %h/%0b want %h/%0b", c, op_rd, op_rd_en, m_op_rd, m_op_rd_en); end
      tests++; if (busy !== m_busy_vec()) begin failed++; $display("[TB] FAIL rnd_busy cyc %0d got %h want %h", c, busy, m_busy_vec()); end
      tests++; if (regs_flat !== m_flat()) begin failed++; $display("[TB] FAIL rnd_regs cyc %0d got %h want %h", c, regs_flat, m_flat()); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); set_in(0, 0, 0, 1, 4'd9, 4'd9, 4'd9, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    tests++; if (op_valid !== 1'b0) begin failed++; $display("[TB] FAIL mid_reset_op_valid got %0b want 0", op_valid); end
    tests++; if (busy !== 16'h0000) begin failed++; $display("[TB] FAIL mid_reset_busy got %h want 0000", busy); end
    tests++; if ({op_a, op_b, op_rd, op_rd_en} !== '0) begin failed++; $display("[TB] FAIL mid_reset_op got a=%h b=%h rd=%h en=%b want 0", op_a, op_b, op_rd, op_rd_en); end
    tests++; if (regs_flat !== '0) begin failed++; $display("[TB] FAIL mid_reset_regs got %h want 0", regs_flat); end
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_raw_stall();
    test_backpressure();
    test_collision();
    test_zero();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
